// File: rtl/sdffe_shreg_pkg.sv
// ----------------------------------------------------------------------------
// Package: sdffe_pkg
// Purpose: shared types and helpers for the sdffe_shreg register chain.
//   shreg_mode_t : per-cycle operation decoded once by the top and fanned out
//                  to every stage.
//   cnt_width()  : width of the occupancy counter able to hold 0..DEPTH.
// Optional feature macro used by the chain: SDFFE_SHREG_ROTATE_EN.
// ----------------------------------------------------------------------------
package sdffe_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'd0,
        MODE_LOAD  = 2'd1,
        MODE_SHIFT = 2'd2,
        MODE_ROT   = 2'd3
    } shreg_mode_t;

    // Counter must represent DEPTH itself, hence DEPTH+1 codes.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sdffe_shreg_stage.sv
// ----------------------------------------------------------------------------
// Module: sdffe_stage
// Purpose: one WIDTH-bit stage of the shift chain plus its valid bit.
// Ports:
//   CLK      in  clock, rising edge
//   n_RES    in  synchronous reset, active low
//   mode     in  operation decoded by the top for this cycle
//   par_d    in  parallel-load data for this stage
//   prev_d   in  data from the upstream stage (or serial/rotate source)
//   prev_vld in  valid bit accompanying prev_d
//   q        out registered stage data
//   vld      out registered stage valid bit
// ----------------------------------------------------------------------------
module sdffe_stage
    import sdffe_pkg::*;
#(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             n_RES,
    input  shreg_mode_t      mode,
    input  logic [WIDTH-1:0] par_d,
    input  logic [WIDTH-1:0] prev_d,
    input  logic             prev_vld,
    output logic [WIDTH-1:0] q,
    output logic             vld
);

    logic [WIDTH-1:0] r_q;
    logic             r_vld;

    // Stage data/valid update: reset, then the mode chosen by the top.
    always_ff @(posedge CLK) begin
        if (!n_RES) begin
            r_q   <= RESET_VAL;
            r_vld <= 1'b0;
        end else begin
            case (mode)
                MODE_LOAD: begin
                    r_q   <= par_d;
                    r_vld <= 1'b1;
                end
                MODE_SHIFT, MODE_ROT: begin
                    r_q   <= prev_d;
                    r_vld <= prev_vld;
                end
                default: begin
                    r_q   <= r_q;
                    r_vld <= r_vld;
                end
            endcase
        end
    end

    assign q   = r_q;
    assign vld = r_vld;

endmodule

// File: rtl/sdffe_shreg.sv
// ----------------------------------------------------------------------------
// Module: sdffe_shreg
// Purpose: WIDTH x DEPTH register chain with keep/enable gating, parallel
//   load, serial shift, per-stage valid tracking and an occupancy count.
// Optional feature: define SDFFE_SHREG_ROTATE_EN to add the rot input, which
//   recirculates stage DEPTH-1 into stage 0 with the count unchanged.
// Ports:
//   CLK       in  clock, rising edge
//   n_RES     in  synchronous reset, active low (beats keep/enable)
//   phi_keep  in  1: hold everything
//   en        in  0: hold everything
//   load      in  parallel load, beats rotate and shift
//   rot       in  (rotate builds only) rotate instead of shift
//   d_par     in  parallel data, stage i = d_par[i*WIDTH +: WIDTH]
//   d_ser     in  serial data into stage 0
//   ser_vld   in  d_ser is valid
//   q_par     out all stages, same packing as d_par
//   q_ser     out stage DEPTH-1
//   nq_ser    out ~q_ser
//   q_vld     out valid bit of stage DEPTH-1
//   cnt       out number of valid stages
//   empty     out cnt == 0
//   full      out cnt == DEPTH
// ----------------------------------------------------------------------------
module sdffe_shreg
    import sdffe_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                          CLK,
    input  logic                          n_RES,
    input  logic                          phi_keep,
    input  logic                          en,
    input  logic                          load,
`ifdef SDFFE_SHREG_ROTATE_EN
    input  logic                          rot,
`endif
    input  logic [WIDTH*DEPTH-1:0]        d_par,
    input  logic [WIDTH-1:0]              d_ser,
    input  logic                          ser_vld,
    output logic [WIDTH*DEPTH-1:0]        q_par,
    output logic [WIDTH-1:0]              q_ser,
    output logic [WIDTH-1:0]              nq_ser,
    output logic                          q_vld,
    output logic [cnt_width(DEPTH)-1:0]   cnt,
    output logic                          empty,
    output logic                          full
);

    localparam int CW = cnt_width(DEPTH);

    shreg_mode_t      w_mode;
    logic [WIDTH-1:0] w_stage_q [DEPTH];
    logic [DEPTH-1:0] w_vld;
    logic [WIDTH-1:0] w_head_d;
    logic             w_head_vld;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_empty;
    logic             r_full;

    // Operation decode; reset is handled inside each register.
    always_comb begin
        if (phi_keep || !en) begin
            w_mode = MODE_HOLD;
        end else if (load) begin
            w_mode = MODE_LOAD;
`ifdef SDFFE_SHREG_ROTATE_EN
        end else if (rot) begin
            w_mode = MODE_ROT;
`endif
        end else begin
            w_mode = MODE_SHIFT;
        end
    end

    // Stage-0 source: the serial input, or the tail stage when rotating.
    always_comb begin
        if (w_mode == MODE_ROT) begin
            w_head_d   = w_stage_q[DEPTH-1];
            w_head_vld = w_vld[DEPTH-1];
        end else begin
            w_head_d   = d_ser;
            w_head_vld = ser_vld;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] w_prev_d;
            logic             w_prev_vld;
            if (gi == 0) begin : g_head
                assign w_prev_d   = w_head_d;
                assign w_prev_vld = w_head_vld;
            end else begin : g_body
                assign w_prev_d   = w_stage_q[gi-1];
                assign w_prev_vld = w_vld[gi-1];
            end

            sdffe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .CLK      (CLK),
                .n_RES    (n_RES),
                .mode     (w_mode),
                .par_d    (d_par[gi*WIDTH +: WIDTH]),
                .prev_d   (w_prev_d),
                .prev_vld (w_prev_vld),
                .q        (w_stage_q[gi]),
                .vld      (w_vld[gi])
            );

            assign q_par[gi*WIDTH +: WIDTH] = w_stage_q[gi];
        end
    endgenerate

    // Next occupancy: one valid in at the head, one out at the tail on a
    // shift, so the count can never leave 0..DEPTH. Rotate keeps it.
    always_comb begin
        w_cnt_nxt = r_cnt;
        case (w_mode)
            MODE_LOAD:  w_cnt_nxt = CW'(DEPTH);
            MODE_SHIFT: w_cnt_nxt = r_cnt + CW'(ser_vld) - CW'(w_vld[DEPTH-1]);
            default:    w_cnt_nxt = r_cnt;
        endcase
    end

    // Occupancy count and its flags, registered together so they agree.
    always_ff @(posedge CLK) begin
        if (!n_RES) begin
            r_cnt   <= {CW{1'b0}};
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_empty <= (w_cnt_nxt == {CW{1'b0}});
            r_full  <= (w_cnt_nxt == CW'(DEPTH));
        end
    end

    assign q_ser  = w_stage_q[DEPTH-1];
    assign nq_ser = ~w_stage_q[DEPTH-1];
    assign q_vld  = w_vld[DEPTH-1];
    assign cnt    = r_cnt;
    assign empty  = r_empty;
    assign full   = r_full;

endmodule

// File: tb/tb_sdffe_shreg.sv
// ----------------------------------------------------------------------------
// Testbench for sdffe_shreg (WIDTH=4, DEPTH=8, RESET_VAL=4'hA).
// Reference model: a queue of {valid,data} entries, head = stage 0; occupancy
// is recomputed as the number of valid entries.
// ----------------------------------------------------------------------------
module tb_sdffe_shreg;

    localparam int W  = 4;
    localparam int D  = 8;
    localparam int CW = 4;
    localparam logic [W-1:0] RV = 4'hA;

    logic             CLK = 1'b0;
    logic             n_RES = 1'b0;
    logic             phi_keep = 1'b0;
    logic             en = 1'b0;
    logic             load = 1'b0;
    logic             rot = 1'b0;
    logic [W*D-1:0]   d_par = '0;
    logic [W-1:0]     d_ser = '0;
    logic             ser_vld = 1'b0;
    logic [W*D-1:0]   q_par;
    logic [W-1:0]     q_ser;
    logic [W-1:0]     nq_ser;
    logic             q_vld;
    logic [CW-1:0]    cnt;
    logic             empty;
    logic             full;

    int checks   = 0;
    int failures = 0;

    logic [W:0] mq[$];   // {valid, data}, index 0 = stage 0

    sdffe_shreg #(
        .WIDTH     (W),
        .DEPTH     (D),
        .RESET_VAL (RV)
    ) dut (
        .CLK      (CLK),
        .n_RES    (n_RES),
        .phi_keep (phi_keep),
        .en       (en),
        .load     (load),
`ifdef SDFFE_SHREG_ROTATE_EN
        .rot      (rot),
`endif
        .d_par    (d_par),
        .d_ser    (d_ser),
        .ser_vld  (ser_vld),
        .q_par    (q_par),
        .q_ser    (q_ser),
        .nq_ser   (nq_ser),
        .q_vld    (q_vld),
        .cnt      (cnt),
        .empty    (empty),
        .full     (full)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply the edge to the model using the currently driven inputs.
    task automatic model_edge();
        logic [W:0] t;
        logic rot_eff;
`ifdef SDFFE_SHREG_ROTATE_EN
        rot_eff = rot;
`else
        rot_eff = 1'b0;
`endif
        if (!n_RES) begin
            mq.delete();
            for (int i = 0; i < D; i++) mq.push_back({1'b0, RV});
        end else if (phi_keep || !en) begin
            // hold
        end else if (load) begin
            mq.delete();
            for (int i = 0; i < D; i++) mq.push_back({1'b1, d_par[i*W +: W]});
        end else if (rot_eff) begin
            t = mq.pop_back();
            mq.push_front(t);
        end else begin
            t = mq.pop_back();
            mq.push_front({ser_vld, d_ser});
        end
    endtask

    function automatic int model_cnt();
        int n = 0;
        foreach (mq[i]) if (mq[i][W]) n++;
        return n;
    endfunction

    function automatic logic [W*D-1:0] model_par();
        logic [W*D-1:0] p;
        for (int i = 0; i < D; i++) p[i*W +: W] = mq[i][W-1:0];
        return p;
    endfunction

    task automatic check_model(input string tag);
        int n;
        n = model_cnt();
        check({tag, ".q_par"},  q_par,  model_par());
        check({tag, ".q_ser"},  {28'd0, q_ser},  {28'd0, mq[D-1][W-1:0]});
        check({tag, ".nq_ser"}, {28'd0, nq_ser}, {28'd0, ~mq[D-1][W-1:0]});
        check({tag, ".q_vld"},  {31'd0, q_vld},  {31'd0, mq[D-1][W]});
        check({tag, ".cnt"},    {28'd0, cnt},    n);
        check({tag, ".empty"},  {31'd0, empty},  {31'd0, (n == 0)});
        check({tag, ".full"},   {31'd0, full},   {31'd0, (n == D)});
    endtask

    // One clock: edge, model update, sample 1 time unit later.
    task automatic step(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        check_model(tag);
    endtask

    initial begin
        // Initial reset brings model and DUT into a known state.
        n_RES = 1'b0;
        step("init_rst");

        // 1. Stale contents, then reset.
        n_RES = 1'b1; en = 1'b1; load = 1'b1;
        d_par = $urandom();
        step("stale_load");
        load = 1'b0; n_RES = 1'b0;
        step("rst");
        check("rst.q_par_const", q_par, {D{RV}});
        check("rst.cnt_const",   {28'd0, cnt}, 32'd0);
        check("rst.empty_const", {31'd0, empty}, 32'd1);
        check("rst.qvld_const",  {31'd0, q_vld}, 32'd0);
        check("rst.nqser_const", {28'd0, nq_ser}, {28'd0, ~RV});

        // 2. Shift in 1..8, then one more while full.
        n_RES = 1'b1; ser_vld = 1'b1;
        for (int i = 1; i <= D; i++) begin
            d_ser = W'(i);
            step("shift_fill");
        end
        check("fill.q_ser_const", {28'd0, q_ser}, 32'd1);
        check("fill.full_const",  {31'd0, full},  32'd1);
        check("fill.cnt_const",   {28'd0, cnt},   32'd8);
        d_ser = 4'h9;
        step("shift_full");
        check("full_shift.cnt_const", {28'd0, cnt}, 32'd8);

        // 3. Keep phase with load requested and d_par changing.
        phi_keep = 1'b1; load = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d_par = $urandom();
            step("keep");
        end
        phi_keep = 1'b0;
        d_par = $urandom();
        step("keep_release");
        check("load.q_par_const", q_par, d_par);
        check("load.cnt_const",   {28'd0, cnt}, 32'd8);
        load = 1'b0;

        // 4. Mixed valids into an empty chain.
        n_RES = 1'b0;
        step("rst2");
        n_RES = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ser_vld = (i % 2 == 0);
            d_ser = $urandom();
            step("mixed_in");
            check("mixed.cnt_const", {28'd0, cnt}, (i < 2) ? ((i == 0) ? 32'd1 : 32'd1) : 32'd2);
        end
        ser_vld = 1'b0;
        for (int i = 0; i < 4; i++) step("mixed_flush");
        check("mixed.qvld0", {31'd0, q_vld}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step("mixed_tail");
            check("mixed.qvld_seq", {31'd0, q_vld}, (i == 1) ? 32'd1 : 32'd0);
        end
        // Empty-side boundary: chain drains to zero and stays there.
        for (int i = 0; i < 6; i++) step("drain");
        check("drain.cnt_const", {28'd0, cnt}, 32'd0);

        // 5. Reset mid-shift with keep asserted.
        for (int i = 0; i < 3; i++) begin
            ser_vld = 1'b1; d_ser = $urandom();
            step("pre_rst_shift");
        end
        phi_keep = 1'b1; n_RES = 1'b0;
        step("rst_keep");
        check("rst_keep.q_par_const", q_par, {D{RV}});
        check("rst_keep.cnt_const",   {28'd0, cnt}, 32'd0);
        phi_keep = 1'b0; n_RES = 1'b1;

`ifdef SDFFE_SHREG_ROTATE_EN
        // 6. Load 0..7 and rotate a full lap.
        load = 1'b1;
        for (int i = 0; i < D; i++) d_par[i*W +: W] = W'(i);
        step("rot_load");
        load = 1'b0; rot = 1'b1;
        for (int i = 0; i < D; i++) begin
            d_ser = $urandom(); ser_vld = $urandom();
            step("rot");
            check("rot.cnt_const", {28'd0, cnt}, 32'd8);
        end
        check("rot.q_par_const", q_par, 32'h76543210);
        rot = 1'b0;
`endif

        // Random phase against the model.
        for (int i = 0; i < 300; i++) begin
            n_RES    = ($urandom_range(0, 31) != 0);
            phi_keep = ($urandom_range(0, 5) == 0);
            en       = ($urandom_range(0, 7) != 0);
            load     = ($urandom_range(0, 9) == 0);
            rot      = ($urandom_range(0, 5) == 0);
            d_par    = $urandom();
            d_ser    = $urandom();
            ser_vld  = $urandom();
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
